level_countdown_timer: RTL
==========================

Name: level_countdown_timer

Overview:
Per-level countdown timer: the producer of the timeUp event and the consumer of the resetTimer and gameOver outputs of the life controller.
- Counts whole seconds down from LEVEL_SECONDS in two BCD digits for the on-screen timer display.
- Emits a one-cycle timeUp pulse when the count reaches 00.
- Reloads whenever resetTimer is high and freezes while gameplay is paused.

Parameters:
CLK_HZ, 31500000, clk cycles per second; prescaler terminal count is CLK_HZ-1
LEVEL_SECONDS, 60, reload value in seconds; legal range 1..99, elaboration error otherwise
WARN_SECONDS, 10, warning threshold in seconds; legal range 0..99
BONUS_SECONDS, 5, seconds added per bonus pulse; used only with TIMER_BONUS_EN

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
resetTimer  in  1  level-sensitive reload request from the life controller
enable  in  1  gameplay active; low pauses the prescaler and the count
gameOver  in  1  game ended; forces the sticky HALT state
timeUp  out  1  registered one-cycle pulse on the 01->00 transition
secondsTens  out  4  BCD tens digit of remaining seconds
secondsOnes  out  4  BCD ones digit of remaining seconds
warning  out  1  registered; high in RUN while 0 < count <= WARN_SECONDS
running  out  1  registered; high while state is RUN
bonusSeconds  in  1  single-cycle pulse; port exists only with TIMER_BONUS_EN

Behaviour:
- Reset (async): state LOAD; digits = LEVEL_SECONDS in BCD; prescaler 0; timeUp, warning and running all 0.
- States are LOAD, RUN, EXPIRED and HALT.
- Priority, highest first: resetN, gameOver, resetTimer, bonus, tick.
- gameOver high in any state -> HALT on the next edge.
  - If resetTimer is high on the same edge, the digits still reload.
  - HALT freezes the digits, keeps timeUp at 0, ignores resetTimer and enable, and exits only via resetN.
- resetTimer high (outside HALT) -> LOAD.
  - Digits reload, prescaler clears, timeUp is 0 on that edge.
  - This holds for every cycle resetTimer stays high.
- LOAD -> RUN on the first edge where resetTimer=0, enable=1 and gameOver=0. The prescaler starts from 0 in that cycle.
- RUN, enable=1: prescaler increments each cycle.
  - At CLK_HZ-1 the prescaler wraps to 0 and a tick decrements the count.
  - Ones 0 borrows from tens: ones becomes 9 and tens decrements.
- RUN, enable=0: prescaler and digits hold their values. No partial-second loss on resume.
- Tick with count 01: digits become 00 and state -> EXPIRED on the same edge. timeUp=1 for exactly that following cycle, then 0.
- EXPIRED: digits stay 00, no further timeUp pulses, waits for resetTimer.
- Tick and resetTimer on the same edge: reload wins, no decrement, no timeUp.
- warning and running are recomputed each edge from the next-state values. Both are 0 in LOAD, EXPIRED and HALT.
- Latency:
  - timeUp is visible one cycle after the terminal tick edge.
  - The digits update on the tick edge itself.
- Prescaler width is $clog2(CLK_HZ). The count never underflows below 00.

Optional Feature:
TIMER_BONUS_EN
- Defined:
  - The bonusSeconds port exists.
  - A pulse in RUN adds BONUS_SECONDS in BCD, saturating at 99; the prescaler is untouched.
  - Bonus coincident with a tick applies both: net change is +BONUS_SECONDS-1.
  - Bonus is ignored in LOAD, EXPIRED and HALT.
- Undefined: the port and the adder are absent; the count only decrements or reloads.

Decomposition:
- Package timer_pkg:
  - state enum typedef (LOAD, RUN, EXPIRED, HALT);
  - bcd_t typedef (logic [3:0]);
  - MAX_SECONDS = 99;
  - function converting an integer 0..99 to two BCD digits.
- Sub-module bcd_down_counter2: two-digit BCD counter with load, decrement-with-borrow, saturating add (macro-gated) and a zero flag.
- The FSM and prescaler stay in the top module.

Test Plan:
All scenarios use CLK_HZ=4, LEVEL_SECONDS=12, WARN_SECONDS=10.
1. Release reset with resetTimer=1 for 3 cycles, then resetTimer=0 and enable=1 -> digits 1,2 and running=1; a single timeUp pulse 48 cycles after RUN entry; digits 0,0; state EXPIRED; no further pulses over 40 cycles.
2. Count at 10, one tick -> secondsTens=0, secondsOnes=9; warning is 0 at 11 and 1 at 10.
3. Drop enable for 20 cycles at prescaler=2, then resume -> digits and prescaler are held; the next tick arrives exactly 20 cycles later than without the pause.
4. resetTimer asserted on the same edge as the 01->00 tick -> no timeUp; digits 1,2; state LOAD.
5. gameOver and resetTimer pulsed together at count 07 -> HALT with digits 1,2 frozen; timeUp and running stay 0; later resetTimer pulses are ignored; resetN pulse returns to LOAD.
6. TIMER_BONUS_EN with LEVEL_SECONDS=97 -> bonus at 97 gives 99; bonus coincident with a tick at 50 gives 54; bonus in EXPIRED leaves 00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the level countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2,
        HALT    = 2'd3
    } timerState_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_SECONDS = 99;

    // Clamps to 0..MAX_SECONDS and returns {tens, ones}.
    function automatic logic [7:0] toBcd(input int value);
        int v;
        v = (value > MAX_SECONDS) ? MAX_SECONDS : ((value < 0) ? 0 : value);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD seconds register: load, decrement with borrow, zero flag.
// With TIMER_BONUS_EN defined, a saturating add is applied before the decrement.
module bcd_down_counter2
    import timer_pkg::*;
#(
    parameter int RESET_VALUE = 60
`ifdef TIMER_BONUS_EN
    ,
    parameter int ADD_VALUE = 5
`endif
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  bcd_t loadTens,
    input  bcd_t loadOnes,
    input  logic dec,
`ifdef TIMER_BONUS_EN
    input  logic add,
`endif
    output bcd_t tens,
    output bcd_t ones,
    output bcd_t nextTens,
    output bcd_t nextOnes,
    output logic nextZero
);

    localparam logic [7:0] RESET_BCD = toBcd(RESET_VALUE);

    bcd_t addTens;
    bcd_t addOnes;

    always_comb begin
        addTens = tens;
        addOnes = ones;
`ifdef TIMER_BONUS_EN
        if (add) begin
            {addTens, addOnes} = toBcd(int'(tens) * 10 + int'(ones) + ADD_VALUE);
        end
`endif
        nextTens = addTens;
        nextOnes = addOnes;
        if (load) begin
            nextTens = loadTens;
            nextOnes = loadOnes;
        end else if (dec) begin
            // 00 holds: the count never wraps below zero.
            if (addOnes != 4'd0) begin
                nextOnes = addOnes - 4'd1;
            end else if (addTens != 4'd0) begin
                nextOnes = 4'd9;
                nextTens = addTens - 4'd1;
            end
        end
        nextZero = (nextTens == 4'd0) && (nextOnes == 4'd0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tens <= RESET_BCD[7:4];
            ones <= RESET_BCD[3:0];
        end else begin
            tens <= nextTens;
            ones <= nextOnes;
        end
    end

endmodule

// File: rtl/level_countdown_timer.sv
// Per-level seconds countdown: prescaler, LOAD/RUN/EXPIRED/HALT FSM, BCD display digits.
// Optional bonus-seconds input enabled by defining TIMER_BONUS_EN.
//   LOAD    | digits hold LEVEL_SECONDS, waiting for enable
//   RUN     | prescaler counting, one-second ticks decrement the digits
//   EXPIRED | reached 00, waiting for resetTimer
//   HALT    | game over, frozen until resetN
module level_countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ        = 31500000,
    parameter int LEVEL_SECONDS = 60,
    parameter int WARN_SECONDS  = 10,
    parameter int BONUS_SECONDS = 5
) (
    input  logic clk,
    input  logic resetN,
    input  logic resetTimer,
    input  logic enable,
    input  logic gameOver,
`ifdef TIMER_BONUS_EN
    input  logic bonusSeconds,
`endif
    output logic timeUp,
    output bcd_t secondsTens,
    output bcd_t secondsOnes,
    output logic warning,
    output logic running
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);
    localparam logic [7:0] LEVEL_BCD = toBcd(LEVEL_SECONDS);

    if (LEVEL_SECONDS < 1 || LEVEL_SECONDS > MAX_SECONDS) begin : gBadLevel
        $error("LEVEL_SECONDS must be in 1..99");
    end
    if (WARN_SECONDS < 0 || WARN_SECONDS > MAX_SECONDS) begin : gBadWarn
        $error("WARN_SECONDS must be in 0..99");
    end
    if (BONUS_SECONDS < 0 || BONUS_SECONDS > MAX_SECONDS) begin : gBadBonus
        $error("BONUS_SECONDS must be in 0..99");
    end
    if (CLK_HZ < 1) begin : gBadClk
        $error("CLK_HZ must be at least 1");
    end

    timerState_t state;
    timerState_t baseState;
    timerState_t nextState;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] nextPrescaler;
    logic load;
    logic tick;
    bcd_t nextTens;
    bcd_t nextOnes;
    logic nextZero;
    logic warnNext;
    int   nextCount;
`ifdef TIMER_BONUS_EN
    logic bonus;
`endif

    always_comb begin
        baseState     = state;
        nextPrescaler = prescaler;
        load          = 1'b0;
        tick          = 1'b0;
`ifdef TIMER_BONUS_EN
        bonus         = 1'b0;
`endif
        // Reload also happens on the edge that enters HALT.
        if (state != HALT && resetTimer) begin
            load          = 1'b1;
            nextPrescaler = '0;
        end
        if (gameOver) begin
            baseState = HALT;
        end else if (state != HALT) begin
            if (resetTimer) begin
                baseState = LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        if (enable) begin
                            baseState     = RUN;
                            nextPrescaler = '0;
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            tick          = (prescaler == PRE_TC);
                            nextPrescaler = tick ? '0 : prescaler + 1'b1;
`ifdef TIMER_BONUS_EN
                            bonus         = bonusSeconds;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        nextState = baseState;
        if (tick && nextZero) begin
            nextState = EXPIRED;
        end
        nextCount = int'(nextTens) * 10 + int'(nextOnes);
        warnNext  = (nextState == RUN) && !nextZero && (nextCount <= WARN_SECONDS);
    end

    bcd_down_counter2 #(
        .RESET_VALUE (LEVEL_SECONDS)
`ifdef TIMER_BONUS_EN
        ,
        .ADD_VALUE   (BONUS_SECONDS)
`endif
    ) uDigits (
        .clk      (clk),
        .resetN   (resetN),
        .load     (load),
        .loadTens (LEVEL_BCD[7:4]),
        .loadOnes (LEVEL_BCD[3:0]),
        .dec      (tick),
`ifdef TIMER_BONUS_EN
        .add      (bonus),
`endif
        .tens     (secondsTens),
        .ones     (secondsOnes),
        .nextTens (nextTens),
        .nextOnes (nextOnes),
        .nextZero (nextZero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= LOAD;
            prescaler <= '0;
            timeUp    <= 1'b0;
            warning   <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= nextState;
            prescaler <= nextPrescaler;
            timeUp    <= (state == RUN) && (nextState == EXPIRED);
            warning   <= warnNext;
            running   <= (nextState == RUN);
        end
    end

endmodule
